// File: rtl/gcd_ctrl.sv
// gcd_ctrl: sequencing FSM for a Euclidean GCD datapath (load, subtract, swap, done/ack).
// Optional feature macro GCD_TIMEOUT_EN bounds CALC at MAX_ITER steps and raises err on expiry.
module gcd_ctrl #(
  parameter int CNT_W    = 8,
  parameter int MAX_ITER = 250
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_a_lt_b,
  input  logic             i_b_eq_0,
  input  logic             i_res_ack,
  output logic             o_a_ld,
  output logic [1:0]       o_a_sel,
  output logic             o_b_ld,
  output logic             o_b_sel,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [CNT_W-1:0] o_iter_cnt
);

  localparam logic [CNT_W-1:0] L_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] L_ITER_LIM = CNT_W'(MAX_ITER);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_iter_cnt;
  logic             w_timeout;
  logic             w_step;

`ifdef GCD_TIMEOUT_EN
  assign w_timeout = (r_state == S_CALC) && !i_b_eq_0 && (r_iter_cnt == L_ITER_LIM);
`else
  // No limit in this build; the compare is masked so both builds share one parameter list.
  assign w_timeout = 1'b0 && (r_iter_cnt == L_ITER_LIM);
`endif

  assign w_step = (r_state == S_CALC) && !i_b_eq_0 && !w_timeout;

  // Strobes are Mealy in CALC: the comparator reflects the registers written on the previous edge.
  always_comb begin
    o_a_ld  = 1'b0;
    o_a_sel = 2'd0;
    o_b_ld  = 1'b0;
    o_b_sel = 1'b0;
    case (r_state)
      S_LOAD: begin
        o_a_ld = 1'b1;
        o_b_ld = 1'b1;
      end
      S_CALC: begin
        if (w_step) begin
          o_a_ld = 1'b1;
          if (i_a_lt_b) begin
            o_a_sel = 2'd2;
            o_b_ld  = 1'b1;
            o_b_sel = 1'b1;
          end else begin
            o_a_sel = 2'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_iter_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          r_iter_cnt <= '0;
          r_err      <= 1'b0;
          r_state    <= S_CALC;
        end
        S_CALC: begin
          if (i_b_eq_0 || w_timeout) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= w_timeout;
          end else if (r_iter_cnt != L_CNT_MAX) begin
            r_iter_cnt <= r_iter_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          // res_ack wins over a simultaneous start; start must be re-asserted in IDLE.
          if (i_res_ack) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: models the A/B operand registers and comparator around the controller.
module tb_gcd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       res_ack;
  logic       a_lt_b;
  logic       b_eq_0;
  logic       a_ld;
  logic [1:0] a_sel;
  logic       b_ld;
  logic       b_sel;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] iter;

  logic [7:0] ra;
  logic [7:0] rb;
  logic [7:0] ext_a;
  logic [7:0] ext_b;
  logic       stuck;

  int total = 0;
  int bad   = 0;

  gcd_ctrl #(.CNT_W(8), .MAX_ITER(250)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_start    (start),
    .i_a_lt_b   (a_lt_b),
    .i_b_eq_0   (b_eq_0),
    .i_res_ack  (res_ack),
    .o_a_ld     (a_ld),
    .o_a_sel    (a_sel),
    .o_b_ld     (b_ld),
    .o_b_sel    (b_sel),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_iter_cnt (iter)
  );

  always #5 clk = ~clk;

  // Operand registers and comparator
  always @(posedge clk) begin
    if (a_ld) begin
      case (a_sel)
        2'd0:    ra <= ext_a;
        2'd1:    ra <= ra - rb;
        2'd2:    ra <= rb;
        default: ra <= ra;
      endcase
    end
    if (b_ld) rb <= b_sel ? ra : ext_b;
  end

  assign a_lt_b = stuck ? 1'b0 : (ra < rb);
  assign b_eq_0 = stuck ? 1'b0 : (rb == 8'd0);

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_a;
    int         exp_iter;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Starts a run and returns the number of edges from the start-sampling edge to done.
  task automatic run_gcd(input logic [7:0] a, input logic [7:0] b, input int limit, output int lat);
    @(negedge clk);
    ext_a = a;
    ext_b = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    chk("busy_in_load", busy, 1);
    while (!done && lat < limit) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic ack_done();
    res_ack = 1'b1;
    @(posedge clk);
    #1;
    res_ack = 1'b0;
    chk("done_drop_after_ack", done, 0);
  endtask

  initial begin
    int lat;
    logic [4:0] pat[7];
    logic [4:0] got;

    vecs[0] = '{a: 8'd12,  b: 8'd8, exp_a: 8'd4, exp_iter: 5,   exp_lat: 8};
    vecs[1] = '{a: 8'd9,   b: 8'd0, exp_a: 8'd9, exp_iter: 0,   exp_lat: 3};
    vecs[2] = '{a: 8'd6,   b: 8'd9, exp_a: 8'd3, exp_iter: 6,   exp_lat: 9};
    vecs[3] = '{a: 8'd5,   b: 8'd5, exp_a: 8'd5, exp_iter: 2,   exp_lat: 5};
    vecs[4] = '{a: 8'd0,   b: 8'd7, exp_a: 8'd7, exp_iter: 1,   exp_lat: 4};
    vecs[5] = '{a: 8'd100, b: 8'd7, exp_a: 8'd1, exp_iter: 22,  exp_lat: 25};
    vecs[6] = '{a: 8'd127, b: 8'd1, exp_a: 8'd1, exp_iter: 128, exp_lat: 131};

    // {a_ld, a_sel, b_ld, b_sel}: LOAD, sub, swap, sub, sub, swap, final CALC
    pat[0] = 5'b10010;
    pat[1] = 5'b10100;
    pat[2] = 5'b11011;
    pat[3] = 5'b10100;
    pat[4] = 5'b10100;
    pat[5] = 5'b11011;
    pat[6] = 5'b00000;

    rst_n = 1'b0; start = 1'b0; res_ack = 1'b0; stuck = 1'b0;
    ext_a = 8'd0; ext_b = 8'd0;
    #12;
    chk("rst_a_ld", a_ld, 0);
    chk("rst_b_ld", b_ld, 0);
    chk("rst_sel", {a_sel, b_sel}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_iter", iter, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_gcd(vecs[i].a, vecs[i].b, 400, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_done", i), done, 1);
      chk($sformatf("v%0d_result_a", i), ra, vecs[i].exp_a);
      chk($sformatf("v%0d_iter", i), iter, vecs[i].exp_iter);
      chk($sformatf("v%0d_err", i), err, 0);
      chk($sformatf("v%0d_busy", i), busy, 0);
      ack_done();
    end

    // Strobe pattern for A=12, B=8
    @(negedge clk);
    ext_a = 8'd12; ext_b = 8'd8; start = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      got = {a_ld, a_sel, b_ld, b_sel};
      chk($sformatf("strobes_step%0d", k), got, pat[k]);
    end
    @(posedge clk);
    #1;
    chk("strobes_done", done, 1);
    chk("strobes_none_in_done", {a_ld, a_sel, b_ld, b_sel}, 0);
    ack_done();

    // Hold DONE for 10 cycles with start pulses that must be ignored
    run_gcd(8'd127, 8'd1, 400, lat);
    chk("hold_result", ra, 1);
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      @(posedge clk);
      #1;
      chk("hold_done", done, 1);
      chk("hold_busy", busy, 0);
    end
    start = 1'b0;
    ack_done();
    @(posedge clk);
    #1;
    chk("idle_after_ack", busy, 0);

    // Reset in the middle of CALC
    @(negedge clk);
    ext_a = 8'd100; ext_b = 8'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("mid_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a_ld", a_ld, 0);
    chk("mid_rst_b_ld", b_ld, 0);
    chk("mid_rst_sel", {a_sel, b_sel}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_iter", iter, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_gcd(8'd100, 8'd7, 400, lat);
    chk("after_rst_result", ra, 1);
    chk("after_rst_latency", lat, 25);
    ack_done();

    // Comparator stuck at a >= b, b != 0
    stuck = 1'b1;
`ifdef GCD_TIMEOUT_EN
    run_gcd(8'd10, 8'd3, 400, lat);
    chk("timeout_latency", lat, 253);
    chk("timeout_done", done, 1);
    chk("timeout_err", err, 1);
    chk("timeout_iter", iter, 250);
    stuck = 1'b0;
    ack_done();
    run_gcd(8'd9, 8'd0, 400, lat);
    chk("err_cleared_by_load", err, 0);
    ack_done();
`else
    run_gcd(8'd10, 8'd3, 300, lat);
    chk("nolimit_done", done, 0);
    chk("nolimit_busy", busy, 1);
    chk("nolimit_iter_sat", iter, 255);
    chk("nolimit_err", err, 0);
    @(negedge clk);
    rst_n = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // start and res_ack together in DONE, start held
    run_gcd(8'd9, 8'd0, 400, lat);
    start = 1'b1;
    res_ack = 1'b1;
    @(posedge clk);
    #1;
    res_ack = 1'b0;
    chk("both_idle_done", done, 0);
    chk("both_idle_busy", busy, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("both_then_load", busy, 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("both_rerun_done", done, 1);
    chk("both_rerun_result", ra, 9);
    // Same collision, start dropped in IDLE: no new run
    start = 1'b1;
    res_ack = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    res_ack = 1'b0;
    chk("both2_done", done, 0);
    @(posedge clk);
    #1;
    chk("both2_stay_idle", busy, 0);
    chk("both2_no_done", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
